// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port valid/ready arbiter and sequencer for a 1-cycle registered-read SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module sram_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   input  logic [DATA_WIDTH-1:0] sram_rdata,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;
   state_t state, state_next;
   logic   owner, any_valid, grant;
`ifndef SRAM_ARB_FIXED_PRIO_EN
   logic   last_grant;
`endif

   always_comb begin
      any_valid = req0_valid || req1_valid;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      grant = !req0_valid;
`else
      grant = (req0_valid && req1_valid) ? !last_grant : req1_valid;
`endif
      req0_ready = (state == IDLE) && any_valid && !grant;
      req1_ready = (state == IDLE) && any_valid && grant;
      busy = state != IDLE;
      // sram_we is high in ISSUE exactly when the owned command is a write
      state_next = (state == IDLE)  ? (any_valid ? ISSUE : IDLE) :
                   (state == ISSUE) ? (sram_we ? IDLE : RDATA) : IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
      end else begin
         state      <= state_next;
         sram_we    <= 1'b0;
         rsp0_valid <= (state == RDATA) && !owner;
         rsp1_valid <= (state == RDATA) && owner;
         if (state == IDLE && any_valid) begin
            sram_we    <= grant ? req1_we : req0_we;
            sram_addr  <= grant ? req1_addr : req0_addr;
            sram_wdata <= grant ? req1_wdata : req0_wdata;
            owner      <= grant;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant <= grant;
`endif
         end
         if (state == RDATA && owner) rsp1_rdata <= sram_rdata;
         if (state == RDATA && !owner) rsp0_rdata <= sram_rdata;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(sram_we && state != ISSUE)) else $error("sram_we outside ISSUE");
         assert (!(rsp0_valid && rsp1_valid)) else $error("both rsp valid");
         assert (!(req0_ready && req1_ready)) else $error("both ready");
      end
   end
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized bench with a transaction-level reference model and an SRAM model.
module tb_sram_arbiter;
   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0, req0_ready, req0_we = 1'b0;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic          rsp0_valid;
   logic [DW-1:0] rsp0_rdata;
   logic          req1_valid = 1'b0, req1_ready, req1_we = 1'b0;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic          rsp1_valid;
   logic [DW-1:0] rsp1_rdata;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata = '0;
   logic          busy;

   sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // single-port SRAM with registered read
   logic [DW-1:0] mem [16];
   always @(posedge clk) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      sram_rdata <= mem[sram_addr];
   end

   int checks = 0, failures = 0, cyc = 0;
   bit mon_en = 1'b0;
   always @(posedge clk) cyc++;

   // transaction-level reference: each accepted command is scheduled on the cycle grid
   typedef struct {int p; int due; logic [DW-1:0] d;} rd_t;
   rd_t pend[$];
   int grant_log[$];
   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
   int busy_until = -1, wr_issue = -10, tb_last = 1;
   int we_cnt = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
   logic ev0, ev1, eb, g, er0, er1;
   int p;

   always @(negedge clk) if (mon_en) begin
      ev0 = 1'b0;
      ev1 = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--)
         if (pend[i].due == cyc) begin
            if (pend[i].p == 0) begin ev0 = 1'b1; exp_rd0 = pend[i].d; end
            else begin ev1 = 1'b1; exp_rd1 = pend[i].d; end
            pend.delete(i);
         end
      eb = cyc <= busy_until;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = (tb_last == 0);
`endif
      er0 = !eb && req0_valid && (!req1_valid || !g);
      er1 = !eb && req1_valid && (!req0_valid || g);
      checks += 8;
      if (busy !== eb) begin failures++; $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
      if (sram_we !== (cyc == wr_issue)) begin failures++; $display("FAIL mon_sram_we cyc=%0d got=%b exp=%b", cyc, sram_we, cyc == wr_issue); end
      if (rsp0_valid !== ev0) begin failures++; $display("FAIL mon_rsp0_valid cyc=%0d got=%b exp=%b", cyc, rsp0_valid, ev0); end
      if (rsp1_valid !== ev1) begin failures++; $display("FAIL mon_rsp1_valid cyc=%0d got=%b exp=%b", cyc, rsp1_valid, ev1); end
      if (rsp0_rdata !== exp_rd0) begin failures++; $display("FAIL mon_rsp0_rdata cyc=%0d got=%h exp=%h", cyc, rsp0_rdata, exp_rd0); end
      if (rsp1_rdata !== exp_rd1) begin failures++; $display("FAIL mon_rsp1_rdata cyc=%0d got=%h exp=%h", cyc, rsp1_rdata, exp_rd1); end
      if (req0_ready !== er0) begin failures++; $display("FAIL mon_req0_ready cyc=%0d got=%b exp=%b", cyc, req0_ready, er0); end
      if (req1_ready !== er1) begin failures++; $display("FAIL mon_req1_ready cyc=%0d got=%b exp=%b", cyc, req1_ready, er1); end
      we_cnt += int'(sram_we);
      rsp_cnt0 += int'(rsp0_valid);
      rsp_cnt1 += int'(rsp1_valid);
      if (rst) begin
         pend.delete();
         busy_until = cyc;
         tb_last = 1;
         exp_rd0 = '0;
         exp_rd1 = '0;
      end else if (er0 || er1) begin
         p = er1 ? 1 : 0;
         grant_log.push_back(p);
         tb_last = p;
         if (p == 0 ? req0_we : req1_we) begin
            if (p == 0) ref_mem[req0_addr] = req0_wdata; else ref_mem[req1_addr] = req1_wdata;
            wr_issue = cyc + 1;
            busy_until = cyc + 1;
         end else begin
            pend.push_back('{p, cyc + 3, p == 0 ? ref_mem[req0_addr] : ref_mem[req1_addr]});
            busy_until = cyc + 2;
         end
      end
   end

   task automatic send(input int port, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int acc);
      int n = 0;
      acc = -1;
      if (port == 0) begin req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1'b1; end
      else begin req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1'b1; end
      forever begin
         @(negedge clk);
         if (!rst && (port == 0 ? req0_ready : req1_ready)) begin acc = cyc; break; end
         if (++n > 400) begin
            checks++; failures++;
            $display("FAIL send_timeout port=%0d got=no_ready exp=ready", port);
            break;
         end
      end
      @(posedge clk); #1;
      if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks += 5;
      if (sram_we !== 1'b0) begin failures++; $display("FAIL reset_sram_we got=%b exp=0", sram_we); end
      if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
      if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if ((rsp0_valid | rsp1_valid) !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b%b exp=00", rsp0_valid, rsp1_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read;
      int acc, w0;
      w0 = we_cnt;
      send(0, 1'b1, 4'd0, 8'hAA, acc);
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (we_cnt - w0 != 1) begin failures++; $display("FAIL wr_we_width got=%0d exp=1", we_cnt - w0); end
      send(0, 1'b0, 4'd0, 8'h00, acc);
      wait_cyc(acc + 2);
      checks++;
      if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL rd_early_pulse got=%b exp=0", rsp0_valid); end
      wait_cyc(acc + 3);
      checks += 2;
      if (rsp0_valid !== 1'b1) begin failures++; $display("FAIL rd_pulse got=%b exp=1", rsp0_valid); end
      if (rsp0_rdata !== 8'hAA) begin failures++; $display("FAIL rd_data got=%h exp=aa", rsp0_rdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_contention;
      int exp_seq [8];
      int acc;
      for (int i = 0; i < 4; i++) send(1, 1'b1, AW'(i), DW'($urandom), acc);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      grant_log.delete();
      fork
         begin int a; for (int i = 0; i < 4; i++) send(0, 1'b0, AW'(i), 8'h00, a); end
         begin int a; for (int i = 0; i < 4; i++) send(1, 1'b0, AW'(i), 8'h00, a); end
      join
      repeat (4) begin @(posedge clk); #1; end
`ifdef SRAM_ARB_FIXED_PRIO_EN
      exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
      exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
      checks++;
      if (grant_log.size() != 8) begin failures++; $display("FAIL contend_count got=%0d exp=8", grant_log.size()); end
      else for (int i = 0; i < 8; i++) begin
         checks++;
         if (grant_log[i] != exp_seq[i]) begin failures++; $display("FAIL contend_grant idx=%0d got=%0d exp=%0d", i, grant_log[i], exp_seq[i]); end
      end
   endtask

   task automatic test_cross;
      int a0, a1, r1;
      r1 = rsp_cnt1;
      fork
         send(1, 1'b1, 4'd1, 8'h55, a1);
         begin @(posedge clk); #1; send(0, 1'b0, 4'd1, 8'h00, a0); end
      join
      wait_cyc(a0 + 3);
      checks += 3;
      if (rsp0_valid !== 1'b1) begin failures++; $display("FAIL cross_pulse got=%b exp=1", rsp0_valid); end
      if (rsp0_rdata !== 8'h55) begin failures++; $display("FAIL cross_data got=%h exp=55", rsp0_rdata); end
      if (rsp_cnt1 != r1) begin failures++; $display("FAIL cross_rsp1 got=%0d exp=%0d", rsp_cnt1, r1); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int acc, r0;
      r0 = rsp_cnt0;
      send(0, 1'b0, 4'd0, 8'h00, acc);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks += 2;
      if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL rstrd_pulse got=%b exp=0", rsp0_valid); end
      if (busy !== 1'b0) begin failures++; $display("FAIL rstrd_busy got=%b exp=0", busy); end
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (rsp_cnt0 != r0) begin failures++; $display("FAIL rstrd_count got=%0d exp=%0d", rsp_cnt0, r0); end
      send(0, 1'b1, 4'd7, 8'h3C, acc);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      send(0, 1'b0, 4'd7, 8'h00, acc);
      wait_cyc(acc + 3);
      checks += 2;
      if (rsp0_valid !== 1'b1) begin failures++; $display("FAIL rstwr_pulse got=%b exp=1", rsp0_valid); end
      if (rsp0_rdata !== 8'h3C) begin failures++; $display("FAIL rstwr_data got=%h exp=3c", rsp0_rdata); end
      @(posedge clk); #1;
   endtask

   task automatic port_random(input int port, input int n);
      int a;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         send(port, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), a);
      end
   endtask

   task automatic test_random;
      int c0 = 0, c1 = 0;
      grant_log.delete();
      fork
         port_random(0, 25);
         port_random(1, 25);
      join
      repeat (5) begin @(posedge clk); #1; end
      foreach (grant_log[i]) if (grant_log[i] == 0) c0++; else c1++;
      checks += 2;
      if (c0 != 25) begin failures++; $display("FAIL rand_grants0 got=%0d exp=25", c0); end
      if (c1 != 25) begin failures++; $display("FAIL rand_grants1 got=%0d exp=25", c1); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      test_reset;
      test_write_read;
      test_contention;
      test_cross;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end
endmodule
